// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the pipelined N:1 result selector.
package mux_pipe_pkg;

    // Width of the saturating illegal-select counter.
    localparam int ERR_CNT_W = 8;

    typedef logic [ERR_CNT_W-1:0] err_cnt_t;

    // A select code is legal when it addresses one of the n_inputs data words.
    function automatic logic sel_is_legal(input int unsigned sel_val,
                                          input int unsigned n_inputs);
        return sel_val < n_inputs;
    endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One elastic register stage: loads when empty or when the next stage takes
// its entry, otherwise holds. Flush empties it and reset clears it.
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic             err_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             err_o,
    output logic [WIDTH-1:0] data_o
);

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t entry_q;
    entry_t entry_d;
    logic   advance;

    // The slot can take a new entry if it is empty or its entry moves on.
    assign advance = !entry_q.valid || ready_i;

    // Next entry: load from upstream when advancing, hold otherwise; flush drops valid only.
    always_comb begin
        entry_d = entry_q;
        if (advance) begin
            entry_d.valid = valid_i;
            entry_d.err   = err_i;
            entry_d.data  = data_i;
        end
        if (flush_i) begin
            entry_d.valid = 1'b0;
        end
    end

    // Stage register; reset clears control and data so outputs are never X.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_o = entry_q.valid;
    assign err_o   = entry_q.err;
    assign data_o  = entry_q.data;

endmodule

// File: rtl/mux_pipe.sv
// Pipelined N:1 data selector with valid/ready on both sides. The select is
// resolved at capture; illegal codes produce zero data and an error flag that
// travels with the entry through STAGES elastic register stages.
module mux_pipe
    import mux_pipe_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int N      = 3,
    parameter  int STAGES = 2,
    localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SW-1:0]        sel,
    input  logic [WIDTH-1:0]     data_in [N],
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Index 0 is the upstream input; index k+1 is the output of stage k.
    logic             vld [STAGES+1];
    logic             erf [STAGES+1];
    logic [WIDTH-1:0] dat [STAGES+1];
    // rdy[k] is ready_k; rdy[STAGES] is the downstream ready.
    logic [STAGES:0]  rdy;

    logic             sel_legal;
    logic [WIDTH-1:0] sel_data;
    logic             in_xfer;
    err_cnt_t         err_count_q;
    err_cnt_t         err_count_d;

    assign sel_legal = sel_is_legal(32'(sel), 32'(N));

    // N:1 select; an out-of-range code matches no input and yields zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i)) begin
                sel_data = data_in[i];
            end
        end
    end

    assign vld[0] = in_valid;
    assign erf[0] = !sel_legal;
    assign dat[0] = sel_data;

    // Ready ripples back from the output: a stage is ready if empty or the next one is.
    always_comb begin : ready_chain
        logic r;
        rdy         = '0;
        r           = out_ready;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r      = !vld[k+1] || r;
            rdy[k] = r;
        end
    end

    assign in_ready = rdy[0];
    assign in_xfer  = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk),
            .reset_i (reset),
            .flush_i (flush),
            .valid_i (vld[k]),
            .err_i   (erf[k]),
            .data_i  (dat[k]),
            .ready_i (rdy[k+1]),
            .valid_o (vld[k+1]),
            .err_o   (erf[k+1]),
            .data_o  (dat[k+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign out_err   = erf[STAGES];
    assign out_data  = dat[STAGES];

    // Count accepted illegal selects, saturating; flushed transfers still count.
    always_comb begin
        err_count_d = err_count_q;
        if (in_xfer && !sel_legal && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: doc/mux_pipe.md
# mux_pipe

Parametrised, pipelined N-to-1 data selector with a valid/ready handshake on both sides. It generalises the datapath's fixed 3:1 combinational selector to any input count and width. It adds STAGES elastic register stages, a flush, and defined behaviour for illegal select codes: zero data plus an error flag, never X. It is used where a result-select point must be retimed across a pipeline boundary, such as the writeback result select in a pipelined RV32I.

## Interface
Parameters:
- WIDTH, 32, data width of every input and of the output
- N, 3, number of data inputs (N ≥ 2)
- STAGES, 2, number of register stages (1..4)
- SW, $clog2(N), select width (derived, not overridable)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream offers sel/data_in this cycle
- in_ready  out  1  block accepts this cycle (transfer = in_valid & in_ready)
- sel  in  SW  selects data_in[sel]
- data_in  in  N×WIDTH  unpacked array of N input words
- flush  in  1  synchronous discard of all in-flight entries
- out_valid  out  1  out_data/out_err hold a valid entry
- out_ready  in  1  downstream accepts (transfer = out_valid & out_ready)
- out_data  out  WIDTH  selected word, delayed STAGES stages
- out_err  out  1  entry was captured with sel ≥ N
- err_count  out  8  saturating count of illegal-select transfers accepted

## Operation
- Selection at capture: data = (sel < N) ? data_in[sel] : '0; err = (sel ≥ N).
- Stage k holds {valid_k, data_k, err_k}. Stage 0 captures the upstream input. Stage STAGES-1 drives the outputs.
- Stage k advances when ready_k = !valid_k | ready_{k+1}. The last stage uses ready_STAGES = out_ready.
- in_ready = ready_0. This is combinational from out_ready through the stage valids, so the pipeline has no bubbles at full throughput.
- When stage k advances, it loads stage k-1's contents (or the upstream input for k=0). valid_k takes the incoming valid.
- A stage that is not advancing holds its contents; data stays stable while out_valid & !out_ready.
- err_count increments on each accepted input transfer with sel ≥ N and saturates at 255. flush does not clear it; only reset does.
- Flush: all valid_k ← 0 next edge. A transfer that coincides with flush is accepted (in_ready unchanged) and discarded. err_count still counts it.
- Reset: all valid_k ← 0, data_k ← 0, err_k ← 0, err_count ← 0. Reset has priority over flush and over any transfer.
- When N is a power of two, every sel value is legal and out_err is constantly 0.

## Timing
- Reset values: in_ready = 1 (all stages empty), out_valid = 0, out_data = 0, out_err = 0, err_count = 0.
- Latency: an input accepted at edge t appears with out_valid = 1 after edge t+STAGES-1 when downstream never stalls. For STAGES = 1 it is visible the cycle after acceptance.
- Throughput: 1 transfer per cycle with out_ready held high.
- Capacity: STAGES entries. With out_ready = 0, in_ready drops after STAGES accepted transfers.
- A simultaneous input and output transfer on a full pipeline is allowed: the pipeline shifts and stays full.
- A reset asserted mid-stream empties the pipeline on that edge. Entries in flight are lost with no partial output.
- Ordering is strictly FIFO. No reordering and no duplication.

## Structure
- Package mux_pipe_pkg holds ERR_CNT_W = 8 and a stage-entry typedef (valid, err, data) parametrised by WIDTH through a module-local struct. The package also holds a function for the legal-select check.
- Sub-module mux_pipe_stage: one elastic register stage with valid/ready, load/hold, flush and reset. It is instantiated STAGES times in a generate loop.
- The selection mux and err_count live in the top module.

## Test plan
- Reset then idle, N=3, STAGES=2: in_ready=1, out_valid=0, out_data=0, err_count=0 for 5 cycles.
- Streaming, out_ready=1, sel=0,1,2 with data_in={0x11111111,0x22222222,0x33333333} → out_data 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, each first valid 2 cycles after acceptance, out_err=0.
- Illegal select: sel=3 with N=3 → entry emerges with out_data=0, out_err=1, err_count=1. Then 300 illegal transfers → err_count saturates at 255.
- Backpressure: out_ready=0, offer 4 words → exactly 2 accepted, in_ready=0, out_data stable. Raise out_ready → both drain in order, then the remaining 2 accepted.
- Flush with the pipeline full plus a concurrent input → out_valid=0 the next cycle. The concurrent word never appears.
- Reset mid-stream, then a parameter sweep N=2/5/8, WIDTH=8/64, STAGES=1/4: outputs return to reset values. Random traffic is compared against a queue model, and out_err is never set when N=8.
